// File: rtl/clock_enable_scheduler_pkg.sv
// Shared types and constants for the clock-enable scheduler and its per-channel tick generators.
package clock_enable_scheduler_pkg;

    localparam int unsigned DIV_WIDTH = 8;

    typedef struct packed {
        logic                 en;
        logic [DIV_WIDTH-1:0] div;
    } chan_cfg_t;

    localparam chan_cfg_t CFG_RESET = '{en: 1'b0, div: '0};

endpackage

// File: rtl/clk_en_channel.sv
// One tick channel: period counter, live/staged ratio registers and the registered tick.
module clk_en_channel
    import clock_enable_scheduler_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_wr_stb,
    input  chan_cfg_t i_wr_cfg,
    input  logic      i_sync,
    output logic      o_tick,
    output logic      o_active,
    output logic      o_pending
);

    chan_cfg_t            r_act, r_stg;
    logic [DIV_WIDTH-1:0] r_cnt;
    logic                 r_pend, r_tick;

    chan_cfg_t            w_act_d, w_stg_d;
    logic [DIV_WIDTH-1:0] w_cnt_d;
    logic                 w_pend_d, w_tick_d;
    logic                 w_wrap, w_apply;

    assign w_wrap  = r_act.en && (r_cnt == r_act.div);
    // Staged values only land at a period boundary, so a smaller div can never strand the counter.
    assign w_apply = r_pend && (w_wrap || !r_act.en || i_sync);

    always_comb begin
        w_act_d  = r_act;
        w_stg_d  = r_stg;
        w_pend_d = r_pend;
        w_cnt_d  = r_cnt;
        w_tick_d = 1'b0;
        if (w_apply) begin
            w_act_d  = r_stg;
            w_pend_d = 1'b0;
            w_cnt_d  = '0;
            w_tick_d = w_wrap && !i_sync;
        end else if (i_sync || !r_act.en) begin
            w_cnt_d = '0;
        end else if (w_wrap) begin
            w_cnt_d  = '0;
            w_tick_d = 1'b1;
        end else begin
            w_cnt_d = r_cnt + DIV_WIDTH'(1);
        end
        if (i_wr_stb) begin
            w_stg_d  = i_wr_cfg;
            w_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act  <= CFG_RESET;
            r_stg  <= CFG_RESET;
            r_cnt  <= '0;
            r_pend <= 1'b0;
            r_tick <= 1'b0;
        end else begin
            r_act  <= w_act_d;
            r_stg  <= w_stg_d;
            r_cnt  <= w_cnt_d;
            r_pend <= w_pend_d;
            r_tick <= w_tick_d;
        end
    end

    assign o_tick    = r_tick;
    assign o_active  = r_act.en;
    assign o_pending = r_pend;

endmodule

// File: rtl/clock_enable_scheduler.sv
// Multi-channel clock-enable generator: config decode, ready/error handling and channel array.
module clock_enable_scheduler
    import clock_enable_scheduler_pkg::*;
#(
    parameter  int unsigned N         = 4,
    parameter  int unsigned DIV_WIDTH = clock_enable_scheduler_pkg::DIV_WIDTH,
    localparam int unsigned CHAN_W    = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CHAN_W-1:0]    cfg_chan,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    input  logic                 cfg_en,
    output logic                 cfg_err,
    input  logic                 sync_req,
    output logic [N-1:0]         o_tick,
    output logic [N-1:0]         o_active,
    output logic [N-1:0]         o_pending
);

    logic      w_in_range, w_accept;
    logic      r_err;
    chan_cfg_t w_wr_cfg;

    assign w_in_range = 32'(cfg_chan) < N;
    // Out-of-range requests are always taken so the requester never stalls; they only flag cfg_err.
    assign cfg_ready  = w_in_range ? !o_pending[cfg_chan] : 1'b1;
    assign w_accept   = cfg_valid && cfg_ready;

    // The channel struct width comes from the package; override DIV_WIDTH there as well.
    always_comb begin
        w_wr_cfg     = CFG_RESET;
        w_wr_cfg.en  = cfg_en;
        w_wr_cfg.div = cfg_div;
    end

    for (genvar g = 0; g < N; g++) begin : g_chan
        logic w_wr_stb;
        assign w_wr_stb = w_accept && w_in_range && (32'(cfg_chan) == g);

        clk_en_channel u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_wr_stb  (w_wr_stb),
            .i_wr_cfg  (w_wr_cfg),
            .i_sync    (sync_req),
            .o_tick    (o_tick[g]),
            .o_active  (o_active[g]),
            .o_pending (o_pending[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_accept && !w_in_range;
        end
    end

    assign cfg_err = r_err;

endmodule

// File: tb/tb_clock_enable_scheduler.sv
// Randomised and directed bench for clock_enable_scheduler against a rule-level reference model.
module tb_clock_enable_scheduler;

    // N=5 leaves channel codes 5..7 unused so the out-of-range path is reachable.
    localparam int N      = 5;
    localparam int DW     = 8;
    localparam int CHAN_W = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_valid, cfg_ready, cfg_en, cfg_err, sync_req;
    logic [CHAN_W-1:0] cfg_chan;
    logic [DW-1:0]     cfg_div;
    logic [N-1:0]      o_tick, o_active, o_pending;

    clock_enable_scheduler #(.N(N), .DIV_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_chan  (cfg_chan),
        .cfg_div   (cfg_div),
        .cfg_en    (cfg_en),
        .cfg_err   (cfg_err),
        .sync_req  (sync_req),
        .o_tick    (o_tick),
        .o_active  (o_active),
        .o_pending (o_pending)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: live and staged settings, phase within period, expected outputs.
    int           m_en   [N];
    int           m_div  [N];
    int           m_cnt  [N];
    int           m_pend [N];
    int           m_sen  [N];
    int           m_sdiv [N];
    logic [N-1:0] m_tick;
    logic         m_err;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_en[i] = 0; m_div[i] = 0; m_cnt[i] = 0;
            m_pend[i] = 0; m_sen[i] = 0; m_sdiv[i] = 0;
        end
        m_tick = '0;
        m_err  = 1'b0;
    endfunction

    function automatic logic exp_ready();
        int ch = int'(cfg_chan);
        if (ch >= N) return 1'b1;
        return m_pend[ch] == 0;
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    function automatic void model_step();
        int  ch     = int'(cfg_chan);
        logic acc   = cfg_valid && exp_ready();
        logic wrap, apply;
        m_err = acc && (ch >= N);
        for (int i = 0; i < N; i++) begin
            wrap      = (m_en[i] != 0) && (m_cnt[i] == m_div[i]);
            apply     = (m_pend[i] != 0) && (wrap || m_en[i] == 0 || sync_req);
            m_tick[i] = wrap && !sync_req;
            if (apply) begin
                m_en[i] = m_sen[i]; m_div[i] = m_sdiv[i];
                m_pend[i] = 0; m_cnt[i] = 0;
            end else if (sync_req || wrap || m_en[i] == 0) begin
                m_cnt[i] = 0;
            end else begin
                m_cnt[i] = m_cnt[i] + 1;
            end
            if (acc && ch == i) begin
                m_sen[i] = int'(cfg_en); m_sdiv[i] = int'(cfg_div); m_pend[i] = 1;
            end
        end
    endfunction

    function automatic logic [N-1:0] pack_en();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_en[i] != 0;
        return v;
    endfunction

    function automatic logic [N-1:0] pack_pend();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_pend[i] != 0;
        return v;
    endfunction

    task automatic step(input logic v, input int ch, input int dv, input logic en, input logic sy);
        cfg_valid = v;
        cfg_chan  = ch[CHAN_W-1:0];
        cfg_div   = dv[DW-1:0];
        cfg_en    = en;
        sync_req  = sy;
        #1;
        check_eq("cfg_ready", 32'(cfg_ready), 32'(exp_ready()));
        model_step();
        @(posedge clk);
        #1;
        check_eq("o_tick", 32'(o_tick), 32'(m_tick));
        check_eq("o_active", 32'(o_active), 32'(pack_en()));
        check_eq("o_pending", 32'(o_pending), 32'(pack_pend()));
        check_eq("cfg_err", 32'(cfg_err), 32'(m_err));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        int k;
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_chan = '0; cfg_div = '0;
        cfg_en = 1'b0; sync_req = 1'b0;
        model_reset();
        #12;
        check_eq("rst_tick", 32'(o_tick), 32'd0);
        check_eq("rst_active", 32'(o_active), 32'd0);
        check_eq("rst_pending", 32'(o_pending), 32'd0);
        check_eq("rst_err", 32'(cfg_err), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // ch0 div=3: staged, applied next clock, first tick four cycles after apply.
        step(1'b1, 0, 3, 1'b1, 1'b0);
        check_eq("ch0_staged", 32'(o_pending[0]), 32'd1);
        idle(1);
        check_eq("ch0_active", 32'(o_active[0]), 32'd1);
        for (k = 1; k <= 20; k++) begin
            idle(1);
            if (o_tick[0]) break;
        end
        check_eq("ch0_first_tick", 32'(k), 32'd4);
        idle(10);

        // ch1 div=7 then shrink to div=1 mid-period.
        step(1'b1, 1, 7, 1'b1, 1'b0);
        idle(4);
        step(1'b1, 1, 1, 1'b1, 1'b0);
        step(1'b0, 1, 0, 1'b0, 1'b0);
        check_eq("ch1_blocked", 32'(cfg_ready), 32'd0);
        idle(16);

        // ch2 div=0 continuous ticks, then disable.
        step(1'b1, 2, 0, 1'b1, 1'b0);
        idle(5);
        step(1'b1, 2, 0, 1'b0, 1'b0);
        idle(4);
        check_eq("ch2_off", 32'(o_active[2]), 32'd0);

        // Sync two channels of different periods.
        step(1'b1, 0, 2, 1'b1, 1'b0);
        step(1'b1, 1, 4, 1'b1, 1'b0);
        idle(13);
        step(1'b0, 0, 0, 1'b0, 1'b1);
        check_eq("sync_no_tick", 32'(o_tick), 32'd0);
        idle(12);

        // Write landing exactly on ch3's wrap.
        step(1'b1, 3, 3, 1'b1, 1'b0);
        idle(1);
        for (int j = 0; j < 10 && m_cnt[3] != 3; j++) idle(1);
        step(1'b1, 3, 5, 1'b1, 1'b0);
        idle(14);

        // Out-of-range channel.
        cfg_valid = 1'b1; cfg_chan = 3'd5; cfg_div = 8'd9; cfg_en = 1'b1; sync_req = 1'b0;
        #1;
        check_eq("oor_ready", 32'(cfg_ready), 32'd1);
        step(1'b1, 5, 9, 1'b1, 1'b0);
        check_eq("oor_err", 32'(cfg_err), 32'd1);
        idle(1);
        check_eq("oor_err_clear", 32'(cfg_err), 32'd0);

        // Asynchronous reset mid-period with updates pending.
        step(1'b1, 4, 6, 1'b1, 1'b0);
        step(1'b1, 0, 1, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_tick", 32'(o_tick), 32'd0);
        check_eq("arst_active", 32'(o_active), 32'd0);
        check_eq("arst_pending", 32'(o_pending), 32'd0);
        model_reset();
        #2;
        rst_n = 1'b1;
        idle(10);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(0, 3) == 0, int'($urandom_range(0, 7)),
                 ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255))
                                             : int'($urandom_range(0, 9)),
                 $urandom_range(0, 4) != 0, $urandom_range(0, 39) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
